// File: rtl/btn_pkg.sv
// Shared types and 25 MHz timing defaults for the front-panel button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        REL_PEND   = 2'b01,
        PRS_STABLE = 2'b10,
        PRS_PEND   = 2'b11
    } deb_state_t;

    localparam int DEF_NUM_BTN         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;   // 4 ms
    localparam int DEF_REPEAT_DELAY    = 6250000;  // 250 ms
    localparam int DEF_REPEAT_RATE     = 1250000;  // 50 ms
    localparam bit DEF_ACTIVE_LOW      = 1'b1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, edge pulses and typematic repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic          REL_PIN  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RAT_LAST = RW'(REPEAT_RATE - 1);

    logic [1:0]    r_sync;
    deb_state_t    r_state;
    deb_state_t    w_next;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_toggle;
    logic          w_s;
    logic          w_level;
    logic [RW-1:0] r_rcnt;
    logic          r_rate_phase;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_sync <= {REL_PIN, REL_PIN};
        else            r_sync <= {r_sync[0], i_raw};
    end

    assign w_s     = ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
    assign w_level = r_state[1];

    always_comb begin
        w_next     = r_state;
        w_dcnt_nxt = '0;
        w_toggle   = 1'b0;
        if (w_s != w_level) begin
            if (r_dcnt == DEB_LAST) begin
                w_toggle = 1'b1;
                w_next   = w_level ? REL_STABLE : PRS_STABLE;
            end else begin
                w_dcnt_nxt = DW'(r_dcnt + 1'b1);
                w_next     = w_level ? PRS_PEND : REL_PEND;
            end
        end else begin
            w_next = w_level ? PRS_STABLE : REL_STABLE;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= REL_STABLE;
            r_dcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dcnt    <= w_dcnt_nxt;
            r_press   <= w_toggle & ~w_level;
            r_release <= w_toggle &  w_level;
        end
    end

    // Repeat counter: first interval is the delay, every later one the rate.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rcnt       <= '0;
            r_rate_phase <= 1'b0;
            r_repeat     <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (w_toggle) begin
                r_rcnt       <= '0;
                r_rate_phase <= 1'b0;
                r_repeat     <= ~w_level;
            end else if (w_level && (REPEAT_DELAY != 0)) begin
                if (r_rcnt == (r_rate_phase ? RAT_LAST : DLY_LAST)) begin
                    r_rcnt       <= '0;
                    r_rate_phase <= 1'b1;
                    r_repeat     <= 1'b1;
                end else begin
                    r_rcnt <= RW'(r_rcnt + 1'b1);
                end
            end else begin
                r_rcnt       <= '0;
                r_rate_phase <= 1'b0;
            end
        end
    end

    assign o_level   = w_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// Front-panel button conditioner: NUM_BTN independent btn_channel instances in the vga_clk domain.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .vga_clk   (vga_clk),
            .sys_rst_n (sys_rst_n),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_repeat  (btn_repeat[g])
        );
    end

endmodule
